// File: rtl/ozdefs.sv
// Shared lane definitions: ordered-set symbol codes, set selector and scheduler states.
// The symbol macros are also visible to any file compiled after this one.
`ifndef OZDEFS_SV
`define OZDEFS_SV
`define COM   8'hBC
`define SKP   8'h1C
`define PAD   8'hF7
`define TS1ID 8'h4A
`define TS2ID 8'h45
`endif

package ozdefs;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    TS1  = 2'd1,
    TS2  = 2'd2,
    SKP  = 2'd3
  } os_sel_t;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_OS   = 2'd2
  } tx_sched_state_t;

  typedef struct packed {
    logic [7:0] linkn;
    logic [7:0] lanen;
    logic [7:0] nfts;
    logic [7:0] dri;
    logic [7:0] tc;
  } ts_fields_t;

  // Returns {txdatak, txdata} for symbol ptr of the given ordered set.
  function automatic logic [8:0] os_symbol(os_sel_t os, logic [3:0] ptr, ts_fields_t f);
    logic [8:0] sym;
    if (ptr == 4'd0) begin
      sym = {1'b1, `COM};
    end else if (os == SKP) begin
      sym = {1'b1, `SKP};
    end else begin
      case (ptr)
        4'd1:    sym = {(f.linkn == `PAD), f.linkn};
        4'd2:    sym = {(f.lanen == `PAD), f.lanen};
        4'd3:    sym = {1'b0, f.nfts};
        4'd4:    sym = {1'b0, f.dri};
        4'd5:    sym = {1'b0, f.tc};
        default: sym = {1'b0, (os == TS2) ? `TS2ID : `TS1ID};
      endcase
    end
    return sym;
  endfunction

endpackage

// File: rtl/os_tx_scheduler_skp.sv
// SKP interval timer: raises pending once every SKP_INTERVAL running cycles,
// holding a single outstanding request until the scheduler takes it.
module skp_interval_timer #(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clr,
  input  logic take,
  output logic pending
);

  localparam logic [15:0] LAST = 16'(SKP_INTERVAL - 1);

  logic [15:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        expire;

  // A fresh expiry wins over a take in the same cycle; repeated expiries never stack.
  always_comb begin
    expire    = run && (count_q == LAST);
    count_d   = count_q;
    pending_d = expire | (pending_q & ~take);
    if (clr) begin
      count_d   = '0;
      pending_d = 1'b0;
    end else if (run) begin
      count_d = expire ? 16'd0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/os_tx_scheduler.sv
// Transmit ordered-set scheduler: arbitrates TS1/TS2/SKP/idle onto one 8-bit lane,
// switching only on set boundaries, with a field shadow and saturating sent-counters.
module os_tx_scheduler
  import ozdefs::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int TS_LEN       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_enable,
  input  logic        req_ts1,
  input  logic        req_ts2,
  input  logic [7:0]  ts_linkn,
  input  logic [7:0]  ts_lanen,
  input  logic [7:0]  ts_nfts,
  input  logic [7:0]  ts_dri,
  input  logic [7:0]  ts_tc,
  input  logic        ctr_clr,
  output logic [7:0]  txdata,
  output logic        txdatak,
  output logic        en_n,
  output logic        os_start,
  output logic        os_done,
  output logic [1:0]  cur_os,
  output logic [15:0] ts1_sent_ctr,
  output logic [15:0] ts2_sent_ctr,
  output logic        skp_pending
);

  localparam logic [3:0] TS_LAST  = 4'(TS_LEN - 1);
  localparam logic [3:0] SKP_LAST = 4'd3;

  tx_sched_state_t state_q;
  os_sel_t         os_q, winner;
  ts_fields_t      fields_q, fields_d;
  logic [3:0]      sym_ptr_q, next_ptr, last_ptr;
  logic [7:0]      txdata_q;
  logic            txdatak_q, en_n_q, os_start_q, os_done_q;
  logic [15:0]     ts1_ctr_q, ts2_ctr_q;
  logic            pending, at_end, arb_cycle, take_skp;
  logic [8:0]      next_sym;

  skp_interval_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (~en_n_q),
    .clr     (state_q == ST_OFF),
    .take    (take_skp),
    .pending (pending)
  );

  // Arbitration happens every idle cycle and on the last symbol of a set.
  always_comb begin
    last_ptr  = (os_q == SKP) ? SKP_LAST : TS_LAST;
    next_ptr  = sym_ptr_q + 4'd1;
    at_end    = (state_q == ST_OS) && (sym_ptr_q == last_ptr);
    arb_cycle = (state_q == ST_IDLE) || at_end;
    winner    = NONE;
    if (pending)      winner = SKP;
    else if (req_ts2) winner = TS2;
    else if (req_ts1) winner = TS1;
    take_skp  = arb_cycle && tx_enable && pending;
    fields_d  = {ts_linkn, ts_lanen, ts_nfts, ts_dri, ts_tc};
    next_sym  = os_symbol(os_q, next_ptr, fields_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_OFF;
      os_q       <= NONE;
      fields_q   <= '0;
      sym_ptr_q  <= '0;
      txdata_q   <= '0;
      txdatak_q  <= 1'b0;
      en_n_q     <= 1'b1;
      os_start_q <= 1'b0;
      os_done_q  <= 1'b0;
      ts1_ctr_q  <= '0;
      ts2_ctr_q  <= '0;
    end else begin
      os_start_q <= 1'b0;
      os_done_q  <= 1'b0;
      case (state_q)
        ST_OFF: begin
          if (tx_enable) begin
            state_q <= ST_IDLE;
            en_n_q  <= 1'b0;
          end
        end
        default: begin
          if ((state_q == ST_OS) && !at_end) begin
            sym_ptr_q              <= next_ptr;
            {txdatak_q, txdata_q}  <= next_sym;
            os_done_q              <= (next_ptr == last_ptr);
          end else if (!tx_enable) begin
            state_q   <= ST_OFF;
            os_q      <= NONE;
            sym_ptr_q <= '0;
            txdata_q  <= '0;
            txdatak_q <= 1'b0;
            en_n_q    <= 1'b1;
          end else if (winner != NONE) begin
            state_q               <= ST_OS;
            os_q                  <= winner;
            fields_q              <= fields_d;
            sym_ptr_q             <= '0;
            {txdatak_q, txdata_q} <= {1'b1, `COM};
            os_start_q            <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
            os_q      <= NONE;
            sym_ptr_q <= '0;
            txdata_q  <= '0;
            txdatak_q <= 1'b0;
          end
        end
      endcase

      // Clear has priority over the completion of a set in the same cycle.
      if (ctr_clr) begin
        ts1_ctr_q <= '0;
        ts2_ctr_q <= '0;
      end else if (os_done_q) begin
        if ((os_q == TS1) && (ts1_ctr_q != 16'hFFFF)) ts1_ctr_q <= ts1_ctr_q + 16'd1;
        if ((os_q == TS2) && (ts2_ctr_q != 16'hFFFF)) ts2_ctr_q <= ts2_ctr_q + 16'd1;
      end
    end
  end

  assign txdata       = txdata_q;
  assign txdatak      = txdatak_q;
  assign en_n         = en_n_q;
  assign os_start     = os_start_q;
  assign os_done      = os_done_q;
  assign cur_os       = os_q;
  assign ts1_sent_ctr = ts1_ctr_q;
  assign ts2_sent_ctr = ts2_ctr_q;
  assign skp_pending  = pending;

endmodule

// File: doc/os_tx_scheduler.md
# os_tx_scheduler

Transmit-side ordered-set scheduler for the single 8-bit symbol lane. It shares the lane between four sources: TS1, TS2 and SKP ordered sets, and logical idle. Ordered sets are switched only on boundaries, and SKP is inserted on a fixed symbol interval. Its txdata/txdatak/en_n outputs drive the same lane the receiver-side queue interface decodes. Training fields come from the LTSSM.

## Interface
Parameters:
- SKP_INTERVAL, 1180: symbols between SKP requests, in the range 16..65535.
- TS_LEN, 16: TS ordered-set length in symbols. Fixed by the receiver's decode.

Ports:
- clk  in  1  symbol clock.
- reset_n  in  1  asynchronous, active-low reset.
- tx_enable  in  1  lane transmit enable.
- req_ts1  in  1  level; keep sending TS1 while high.
- req_ts2  in  1  level; keep sending TS2 while high. Has priority over TS1.
- ts_linkn, ts_lanen, ts_nfts, ts_dri, ts_tc  in  8 each  TS fields for symbols 1..5. The value `PAD means PAD.
- ctr_clr  in  1  synchronous clear of both sent-counters.
- txdata  out  8  symbol.
- txdatak  out  1  K-character flag.
- en_n  out  1  active-low lane-valid.
- os_start  out  1  pulse on symbol 0 of any ordered set.
- os_done  out  1  pulse on the last symbol of any ordered set.
- cur_os  out  2  os_sel_t of the set in flight: NONE/TS1/TS2/SKP.
- ts1_sent_ctr, ts2_sent_ctr  out  16 each  completed TS counts, saturating.
- skp_pending  out  1  SKP owed, not yet started.

## Operation
- State machine has three states.
  - ST_OFF: lane disabled.
  - ST_IDLE: sending logical idle, which is txdata 8'h00, txdatak 0.
  - ST_OS: sending an ordered set.
- Symbol counter sym_ptr is 4 bits and counts 0..len-1. len = TS_LEN for TS1/TS2 and 4 for SKP.
- Arbitration is evaluated in ST_IDLE every cycle, and in ST_OS only on the os_done cycle.
  - Priority: skp_pending > req_ts2 > req_ts1 > idle.
  - The winner's symbol 0 appears on the following cycle.
  - A request dropped mid-set does not truncate the set.
- TS layout (matches receiver decode):
  - Symbol 0: `COM, K.
  - Symbols 1..5: link, lane, nfts, dri, tc.
  - Symbols 6..15: `TS1ID or `TS2ID, D.
  - Symbols 1 and 2 carry txdatak=1 iff their value equals `PAD. Symbols 3..5 are always D.
- The five field inputs are captured into a shadow register on the arbitration cycle. Field changes mid-set have no effect.
- SKP layout: `COM followed by three `SKP, all K.
- SKP timer:
  - Counts every clock while en_n=0.
  - On reaching SKP_INTERVAL-1 it sets skp_pending and wraps to 0.
  - skp_pending clears on the os_start of the SKP.
  - A second expiry while pending does not queue a second SKP.
- Counters: ts1_sent_ctr/ts2_sent_ctr increment on os_done of their type and saturate at 16'hFFFF.
  - ctr_clr wins over a simultaneous increment.
- tx_enable deasserted:
  - In ST_IDLE: go to ST_OFF next cycle.
  - In ST_OS: finish the set, then go to ST_OFF.
- In ST_OFF:
  - en_n=1, txdata=0, txdatak=0.
  - SKP timer and skp_pending are cleared.
  - Exit to ST_IDLE on tx_enable=1.

## Timing
- All outputs are registered.
- Reset values: txdata=0, txdatak=0, en_n=1, os_start=0, os_done=0, cur_os=NONE, both counters=0, skp_pending=0. State is ST_OFF, sym_ptr=0, SKP timer=0.
- Reset asserted mid-set aborts immediately with no os_done.
- Request to COM latency: 1 cycle from ST_IDLE. From ST_OS, symbol 0 follows the os_done symbol with no gap.
- Sustained TS1 gives one set per 16 cycles, back to back.
- A SKP becoming pending mid-TS is sent immediately after that TS. Worst-case SKP delay is TS_LEN-1 cycles.
- os_start and os_done are simultaneous only if len=1, which never occurs.

## Structure
- Shared package ozdefs.sv holds:
  - `COM, `SKP, `PAD, `TS1ID, `TS2ID;
  - new typedef os_sel_t {NONE, TS1, TS2, SKP}, reusing OsType if that is equivalent;
  - the state enum tx_sched_state_t.
- Sub-module skp_interval_timer, parameter SKP_INTERVAL:
  - inputs clk, reset_n, run, clr, take;
  - output pending.
- The top level holds the arbiter, sequencer, field shadow and counters.

## Test plan
- Reset, then tx_enable=1 with no requests: en_n=0 from cycle 2, idle 8'h00/K=0, until a SKP (COM,SKP,SKP,SKP, all K) at cycle SKP_INTERVAL+1.
- req_ts1 held, linkn=`PAD, lanen=8'h03: repeated sets `COM,F7(K),03(D),nfts,dri,tc,10×`TS1ID. ts1_sent_ctr=4 after 64 cycles. The receiver queue decodes TS1.
- req_ts1 and req_ts2 both high: only TS2 is sent. Drop req_ts2 mid-set: current TS2 completes, then TS1 begins on the next cycle.
- SKP_INTERVAL=20 with TS1 streaming: SKP follows the TS whose span covers the expiry, with no gap. A SKP expiry while already pending yields exactly one SKP.
- tx_enable=0 at sym_ptr=5: set completes, os_done at symbol 15, en_n=1 next cycle. ctr_clr coincident with os_done gives counter=0.
- reset_n low at sym_ptr=9: outputs return to reset values immediately. After release, state is ST_OFF and the next set starts at symbol 0.
